// File: rtl/axi_rb.sv
// AXI4 read-burst initiator: issues one INCR burst on AR, collects R beats into a
// 2-entry skid buffer and forwards them in order to a downstream FIFO write port.
module axi_rb #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  output logic [ADDR_WIDTH-1:0] s_axi_araddr,
  output logic [LEN_WIDTH-1:0]  s_axi_arlen,
  output logic [2:0]            s_axi_arsize,
  output logic [1:0]            s_axi_arburst,
  output logic                  s_axi_arvalid,
  input  logic                  s_axi_arready,
  input  logic [DATA_WIDTH-1:0] s_axi_rdata,
  input  logic [1:0]            s_axi_rresp,
  input  logic                  s_axi_rlast,
  input  logic                  s_axi_rvalid,
  output logic                  s_axi_rready,
  output logic [DATA_WIDTH-1:0] fifo_in_data,
  output logic                  fifo_write_valid,
  input  logic                  fifo_write_ready,
  output logic                  valid,
  output logic                  err
);

  localparam logic [2:0] ARSIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [2:0] {S_IDLE, S_AR, S_DATA, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf1_q;
  logic [LEN_WIDTH:0]    beat_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  rready_q, rready_d;
  logic                  err_q;
  logic                  start_ok, accept, pop, last_idx, beat_err;

  assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
  assign accept   = s_axi_rvalid && rready_q;
  assign pop      = (count_q != 2'd0) && fifo_write_ready;
  assign last_idx = (beat_q == {1'b0, len_q});
  // Any bad response, or rlast disagreeing with the expected final index.
  assign beat_err = accept && ((s_axi_rresp != 2'b00) || (s_axi_rlast != last_idx));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_AR;
      S_AR:    if (s_axi_arready) state_d = S_DATA;
      S_DATA:  if (accept && s_axi_rlast) state_d = S_DRAIN;
      S_DRAIN: if (count_q == 2'd0) state_d = S_DONE;
      S_DONE:  if (start_ok) state_d = S_AR;
      default: state_d = S_IDLE;
    endcase
  end

  // rready is registered from next-state/next-count so the FIFO side never
  // reaches the R channel combinationally; count_d < 2 leaves room for one more beat.
  always_comb begin
    count_d  = count_q + {1'b0, accept} - {1'b0, pop};
    rready_d = (state_d == S_DATA) && (count_d < 2'd2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      rready_q <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rready_q <= rready_d;
      if (start_ok) begin
        addr_q <= cfg_addr;
        len_q  <= cfg_len;
        beat_q <= '0;
        err_q  <= 1'b0;
      end else begin
        if (accept && beat_q != '1) beat_q <= beat_q + {{LEN_WIDTH{1'b0}}, 1'b1};
        if (beat_err) err_q <= 1'b1;
      end
    end
  end

  // Skid buffer: buf0 is the head; accept never coincides with a full buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      if (pop && count_q == 2'd2) buf0_q <= buf1_q;
      if (accept) begin
        if (count_q == 2'd0 || (count_q == 2'd1 && pop)) buf0_q <= s_axi_rdata;
        else buf1_q <= s_axi_rdata;
      end
    end
  end

  assign s_axi_araddr     = addr_q;
  assign s_axi_arlen      = len_q;
  assign s_axi_arsize     = ARSIZE;
  assign s_axi_arburst    = 2'b01;
  assign s_axi_arvalid    = (state_q == S_AR);
  assign s_axi_rready     = rready_q;
  assign fifo_in_data     = buf0_q;
  assign fifo_write_valid = (count_q != 2'd0);
  assign valid            = (state_q == S_DONE);
  assign err              = err_q;

endmodule

// File: tb/tb_axi_rb.sv
// Scoreboard bench for axi_rb: R beats issued by the bench are queued as expected
// FIFO writes; an independent monitor pops and compares on each FIFO handshake.
module tb_axi_rb;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [LW-1:0] cfg_len = '0;
  logic [AW-1:0] s_axi_araddr;
  logic [LW-1:0] s_axi_arlen;
  logic [2:0]    s_axi_arsize;
  logic [1:0]    s_axi_arburst;
  logic          s_axi_arvalid;
  logic          s_axi_arready = 1'b0;
  logic [DW-1:0] s_axi_rdata = '0;
  logic [1:0]    s_axi_rresp = '0;
  logic          s_axi_rlast = 1'b0;
  logic          s_axi_rvalid = 1'b0;
  logic          s_axi_rready;
  logic [DW-1:0] fifo_in_data;
  logic          fifo_write_valid;
  logic          fifo_write_ready;
  logic          valid;
  logic          err;

  axi_rb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .fifo_in_data(fifo_in_data), .fifo_write_valid(fifo_write_valid),
    .fifo_write_ready(fifo_write_ready), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int            passed = 0;
  int            total = 0;
  logic [DW-1:0] exp_q[$];
  int            wr_cyc[$];
  int            occ = 0;
  int            stall_lo = -1;
  int            stall_hi = -1;
  int            fifo_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // FIFO-side ready: always ready, random, or forced low inside a stall window.
  initial begin
    fifo_write_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cyc >= stall_lo && cyc <= stall_hi) fifo_write_ready = 1'b0;
      else if (fifo_mode == 1) fifo_write_ready = 1'($urandom_range(0, 1));
      else fifo_write_ready = 1'b1;
    end
  end

  // Monitor: occupancy is the number of beats accepted on R but not yet written out.
  always @(negedge clk) begin
    if (!rst) occ = 0;
    else begin
      chk("wvalid_vs_occupancy", fifo_write_valid, occ != 0);
      if (fifo_write_valid && fifo_write_ready) begin
        if (exp_q.size() == 0) chk("fifo_extra_write", fifo_write_valid, 0);
        else chk("fifo_data", fifo_in_data, exp_q.pop_front());
        wr_cyc.push_back(cyc);
      end
      occ = occ + int'(s_axi_rvalid && s_axi_rready) - int'(fifo_write_valid && fifo_write_ready);
      if (s_axi_rvalid && s_axi_rready) chk("buffer_bound", occ <= 2, 1);
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_arvalid"}, s_axi_arvalid, 0);
    chk({tag, "_araddr"}, s_axi_araddr, 0);
    chk({tag, "_arlen"}, s_axi_arlen, 0);
    chk({tag, "_rready"}, s_axi_rready, 0);
    chk({tag, "_fifo_data"}, fifo_in_data, 0);
    chk({tag, "_fifo_valid"}, fifo_write_valid, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_arsize"}, s_axi_arsize, 2);
    chk({tag, "_arburst"}, s_axi_arburst, 1);
  endtask

  task automatic do_start(input logic [AW-1:0] a, input logic [LW-1:0] l);
    @(posedge clk); #1;
    start = 1'b1; cfg_addr = a; cfg_len = l;
    @(posedge clk); #1;
    start = 1'b0; cfg_addr = AW'($urandom); cfg_len = LW'($urandom);
  endtask

  // Optional 'poke' holds a conflicting start during the AR wait; it must be ignored.
  task automatic do_ar(input logic [AW-1:0] a, input logic [LW-1:0] l, input int delay, input bit poke);
    for (int d = 0; d <= delay; d++) begin
      s_axi_arready = (d == delay);
      if (poke && d < delay) begin start = 1'b1; cfg_addr = ~a; cfg_len = ~l; end
      else start = 1'b0;
      @(negedge clk);
      if (d == 0) begin
        chk("valid_cleared_on_start", valid, 0);
        chk("err_cleared_on_start", err, 0);
      end
      chk("arvalid_held", s_axi_arvalid, 1);
      chk("araddr", s_axi_araddr, a);
      chk("arlen", s_axi_arlen, l);
      if (d == delay) begin
        chk("arsize", s_axi_arsize, 2);
        chk("arburst", s_axi_arburst, 1);
      end
      @(posedge clk); #1;
    end
    s_axi_arready = 1'b0;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] data, input bit last, input logic [1:0] resp, input bit chk_ar);
    bit got;
    got = 1'b0;
    s_axi_rvalid = 1'b1; s_axi_rdata = data; s_axi_rlast = last; s_axi_rresp = resp;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (chk_ar && t == 0) chk("arvalid_dropped", s_axi_arvalid, 0);
      got = s_axi_rready;
      @(posedge clk); #1;
    end
    if (!got) chk("r_handshake_timeout", got, 1);
    else exp_q.push_back(data);
    s_axi_rvalid = 1'b0; s_axi_rlast = 1'b0; s_axi_rresp = 2'b00;
  endtask

  task automatic burst(input logic [AW-1:0] a, input logic [LW-1:0] l, input int nbeats, input int bad,
                       input int delay, input bit poke, input bit gaps, input int stall_after,
                       input bit use_base, input logic [DW-1:0] base);
    bit got;
    bit exp_err;
    logic [DW-1:0] d;
    exp_err = (bad >= 0 && bad < nbeats) || (nbeats != int'(l) + 1);
    do_start(a, l);
    do_ar(a, l, delay, poke);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      d = use_base ? base + DW'(i) : DW'($urandom);
      send_beat(d, i == nbeats - 1, (i == bad) ? 2'b10 : 2'b00, i == 0);
      if (i == stall_after) begin stall_lo = cyc + 1; stall_hi = cyc + 4; end
    end
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = valid;
    end
    chk("done_valid", valid, 1);
    chk("done_err", err, exp_err);
    chk("all_beats_delivered", exp_q.size(), 0);
  endtask

  initial begin
    logic [LW-1:0] l;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;

    // Basic burst: A0..A3 must appear on four consecutive FIFO cycles.
    wr_cyc.delete();
    burst(16'h0100, 8'd3, 4, -1, 0, 1'b0, 1'b0, -1, 1'b1, 32'h0000_00A0);
    chk("basic_write_count", wr_cyc.size(), 4);
    if (wr_cyc.size() == 4) chk("basic_consecutive", wr_cyc[3] - wr_cyc[0], 3);

    // arready held low 5 cycles while a stray start is pending.
    burst(16'h1234, 8'd2, 3, -1, 5, 1'b1, 1'b0, -1, 1'b0, '0);

    // FIFO stalls 4 cycles mid-burst.
    burst(16'h4000, 8'd7, 8, -1, 0, 1'b0, 1'b1, 2, 1'b0, '0);

    // Single-beat burst, then a start from DONE.
    burst(16'h0040, 8'd0, 1, -1, 0, 1'b0, 1'b0, -1, 1'b1, 32'hDEAD_BEEF);
    burst(16'h0080, 8'd2, 3, -1, 1, 1'b0, 1'b0, -1, 1'b0, '0);

    // Error cases: early rlast, bad response, late rlast.
    burst(16'h0500, 8'd3, 2, -1, 0, 1'b0, 1'b0, -1, 1'b0, '0);
    burst(16'h0600, 8'd3, 4, 2, 0, 1'b0, 1'b0, -1, 1'b0, '0);
    burst(16'h0700, 8'd1, 3, -1, 0, 1'b0, 1'b0, -1, 1'b0, '0);
    burst(16'h0800, 8'd2, 3, -1, 0, 1'b0, 1'b0, -1, 1'b0, '0);

    // Randomized bursts with a random-ready FIFO.
    fifo_mode = 1;
    for (int n = 0; n < 10; n++) begin
      l = LW'($urandom_range(0, 15));
      burst(AW'($urandom), l, int'(l) + 1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(l))) : -1,
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, -1, 1'b0, '0);
    end
    fifo_mode = 0;

    // Asynchronous reset in the middle of the data phase.
    do_start(16'h0300, 8'd3);
    do_ar(16'h0300, 8'd3, 0, 1'b0);
    send_beat(32'h1111_1111, 1'b0, 2'b00, 1'b1);
    send_beat(32'h2222_2222, 1'b0, 2'b00, 1'b0);
    s_axi_rvalid = 1'b1; s_axi_rdata = 32'h3333_3333;
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    exp_q.delete();
    s_axi_rvalid = 1'b0;
    @(posedge clk); #1;
    chk("reset_hold_valid", valid, 0);
    chk("reset_hold_arvalid", s_axi_arvalid, 0);
    rst = 1'b1;
    burst(16'h0200, 8'd1, 2, -1, 0, 1'b0, 1'b0, -1, 1'b0, '0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
